// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: opcodes, fetch defaults, fetch FSM encoding
// and the IF/ID bundle.
package fetch_stage_pkg;

    localparam logic [3:0] OP_HLT = 4'hF;
    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_LHB = 4'hA;
    localparam logic [3:0] OP_LLB = 4'hB;

    localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;
    localparam logic [15:0] RESET_PC_DEF  = 16'h0000;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_plus2;
        logic        valid;
    } if_id_t;

    function automatic logic is_hlt(input logic [15:0] instr);
        return instr[15:12] == OP_HLT;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: clear (bubble) beats hold, hold beats load.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        clear,
    input  logic [15:0] load_instr,
    input  logic [15:0] load_pc_plus2,
    output logic [15:0] instr,
    output logic [15:0] pc_plus2,
    output logic        valid
);

    if_id_t ifid_q;
    if_id_t ifid_d;

    always_comb begin
        ifid_d = ifid_q;
        if (clear) begin
            ifid_d.instr    = NOP_INSTR;
            ifid_d.pc_plus2 = 16'h0000;
            ifid_d.valid    = 1'b0;
        end else if (!hold) begin
            ifid_d.instr    = load_instr;
            ifid_d.pc_plus2 = load_pc_plus2;
            ifid_d.valid    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_q.instr    <= NOP_INSTR;
            ifid_q.pc_plus2 <= 16'h0000;
            ifid_q.valid    <= 1'b0;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign instr    = ifid_q.instr;
    assign pc_plus2 = ifid_q.pc_plus2;
    assign valid    = ifid_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, FETCH/HALTED state machine, delivered-instruction
// counter, feeding the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] branch_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus2,
    output logic        if_id_valid,
    output logic        halted,
    output logic [15:0] instr_count
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  count_q, count_d;
    logic [15:0]  pc_plus2;
    logic         ifid_hold;
    logic         ifid_clear;
    logic         unused_target_lsb;

    assign pc_plus2          = pc_q + 16'd2;
    assign unused_target_lsb = branch_target[0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        ifid_hold  = 1'b0;
        ifid_clear = 1'b0;
        if (flush) begin
            pc_d       = {branch_target[15:1], 1'b0};
            state_d    = FETCH;
            ifid_clear = 1'b1;
        end else if (stall) begin
            ifid_hold = 1'b1;
        end else begin
            unique case (state_q)
                FETCH: begin
                    count_d = count_q + 16'd1;
                    if (is_hlt(imem_data)) begin
                        state_d = HALTED;
                    end else begin
                        pc_d = pc_plus2;
                    end
                end
                HALTED: begin
                    ifid_clear = 1'b1;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= {RESET_PC[15:1], 1'b0};
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk          (clk),
        .rst          (rst),
        .hold         (ifid_hold),
        .clear        (ifid_clear),
        .load_instr   (imem_data),
        .load_pc_plus2(pc_plus2),
        .instr        (if_id_instr),
        .pc_plus2     (if_id_pc_plus2),
        .valid        (if_id_valid)
    );

    assign imem_addr   = pc_q;
    assign halted      = (state_q == HALTED);
    assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle comparison against a
// behavioural fetch model plus literal checkpoints.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [15:0] branch_target;

    logic [15:0] imem_addr, imem_data;
    logic [15:0] if_id_instr, if_id_pc_plus2, instr_count;
    logic        if_id_valid, halted;

    logic [15:0] w_addr, w_data;
    logic [15:0] w_instr, w_pc_plus2, w_count;
    logic        w_valid, w_halted;

    logic [15:0] mem [0:127];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [15:0] rd(input logic [15:0] a);
        if (a[15:8] == 8'h00) return mem[a[7:1]];
        return {4'h2, a[11:0]};
    endfunction

    assign imem_data = rd(imem_addr);
    assign w_data    = rd(w_addr);

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus2(if_id_pc_plus2),
        .if_id_valid   (if_id_valid),
        .halted        (halted),
        .instr_count   (instr_count)
    );

    fetch_stage #(.RESET_PC(16'hFFFE)) u_wrap (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .imem_addr     (w_addr),
        .imem_data     (w_data),
        .if_id_instr   (w_instr),
        .if_id_pc_plus2(w_pc_plus2),
        .if_id_valid   (w_valid),
        .halted        (w_halted),
        .instr_count   (w_count)
    );

    // behavioural model of the fetch rules
    logic [15:0] m_pc, m_instr, m_pp2, m_cnt;
    logic        m_valid, m_halt;

    always @(posedge clk) begin
        if (rst) begin
            m_pc    <= 16'h0000;
            m_halt  <= 1'b0;
            m_cnt   <= 16'h0000;
            m_instr <= 16'h0000;
            m_pp2   <= 16'h0000;
            m_valid <= 1'b0;
        end else if (flush) begin
            m_pc    <= branch_target & 16'hFFFE;
            m_halt  <= 1'b0;
            m_instr <= 16'h0000;
            m_pp2   <= 16'h0000;
            m_valid <= 1'b0;
        end else if (stall) begin
            m_pc <= m_pc;
        end else if (m_halt) begin
            m_instr <= 16'h0000;
            m_pp2   <= 16'h0000;
            m_valid <= 1'b0;
        end else begin
            m_instr <= rd(m_pc);
            m_pp2   <= m_pc + 16'd2;
            m_valid <= 1'b1;
            m_cnt   <= m_cnt + 16'd1;
            if (rd(m_pc) >= 16'hF000) m_halt <= 1'b1;
            else m_pc <= m_pc + 16'd2;
        end
    end

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_addr", imem_addr, m_pc);
            chk("m_instr", if_id_instr, m_instr);
            chk("m_pc_plus2", if_id_pc_plus2, m_pp2);
            chk("m_valid", {15'd0, if_id_valid}, {15'd0, m_valid});
            chk("m_halted", {15'd0, halted}, {15'd0, m_halt});
            chk("m_count", instr_count, m_cnt);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'h6000 | 16'(i);
        mem[0]    = 16'h1123;
        mem[1]    = 16'h2456;
        mem[2]    = 16'h3789;
        mem[3]    = 16'hF000;
        mem[8]    = 16'h5555;
        mem[8'h20] = 16'h7ABC;
        mem[8'h30] = 16'h1001;
        mem[8'h31] = 16'h1002;
        mem[8'h32] = 16'h1003;
        mem[8'h33] = 16'h1004;
        mem[8'h34] = 16'hF000;

        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        branch_target = 16'h0000;
        tick(2);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_valid", {15'd0, if_id_valid}, 16'h0000);
        chk("rst_instr", if_id_instr, 16'h0000);
        chk("rst_count", instr_count, 16'h0000);
        chk("wrap_rst_addr", w_addr, 16'hFFFE);
        chk_en = 1'b1;
        rst = 1'b0;

        tick(1);
        chk("run1_instr", if_id_instr, 16'h1123);
        chk("run1_pp2", if_id_pc_plus2, 16'h0002);
        chk("run1_addr", imem_addr, 16'h0002);
        chk("wrap_pp2", w_pc_plus2, 16'h0000);
        chk("wrap_addr", w_addr, 16'h0000);
        chk("wrap_instr", w_instr, 16'h2FFE);
        chk("wrap_valid", {15'd0, w_valid}, 16'h0001);
        chk("wrap_halted", {15'd0, w_halted}, 16'h0000);
        chk("wrap_count", w_count, 16'h0001);

        tick(1);
        chk("run2_instr", if_id_instr, 16'h2456);
        chk("run2_pp2", if_id_pc_plus2, 16'h0004);
        stall = 1'b1;
        tick(1);
        chk("stall1_addr", imem_addr, 16'h0004);
        chk("stall1_instr", if_id_instr, 16'h2456);
        tick(1);
        chk("stall2_instr", if_id_instr, 16'h2456);
        chk("stall2_count", instr_count, 16'h0002);
        stall = 1'b0;

        tick(1);
        chk("run3_instr", if_id_instr, 16'h3789);
        chk("run3_pp2", if_id_pc_plus2, 16'h0006);
        chk("run3_count", instr_count, 16'h0003);

        tick(1);
        chk("hlt_instr", if_id_instr, 16'hF000);
        chk("hlt_halted", {15'd0, halted}, 16'h0001);
        chk("hlt_addr", imem_addr, 16'h0006);
        stall = 1'b1;
        tick(2);
        chk("hlt_stall_instr", if_id_instr, 16'hF000);
        chk("hlt_stall_valid", {15'd0, if_id_valid}, 16'h0001);
        stall = 1'b0;
        tick(10);
        chk("hlt_hold_addr", imem_addr, 16'h0006);
        chk("hlt_bubble", {15'd0, if_id_valid}, 16'h0000);

        flush = 1'b1;
        branch_target = 16'h0010;
        tick(1);
        flush = 1'b0;
        chk("resume_halted", {15'd0, halted}, 16'h0000);
        chk("resume_addr", imem_addr, 16'h0010);
        tick(1);
        chk("resume_instr", if_id_instr, 16'h5555);
        chk("resume_pp2", if_id_pc_plus2, 16'h0012);

        flush = 1'b1;
        branch_target = 16'h0009;
        tick(1);
        chk("flush_lsb_addr", imem_addr, 16'h0008);
        stall = 1'b1;
        branch_target = 16'h0041;
        tick(1);
        stall = 1'b0;
        flush = 1'b0;
        chk("fs_addr", imem_addr, 16'h0040);
        chk("fs_valid", {15'd0, if_id_valid}, 16'h0000);
        chk("fs_instr", if_id_instr, 16'h0000);
        tick(1);
        chk("fs_tgt_instr", if_id_instr, 16'h7ABC);
        chk("fs_tgt_pp2", if_id_pc_plus2, 16'h0042);
        tick(3);

        flush = 1'b1;
        branch_target = 16'hFFFF;
        tick(1);
        flush = 1'b0;
        chk("fwrap_addr", imem_addr, 16'hFFFE);
        tick(1);
        chk("fwrap_instr", if_id_instr, 16'h2FFE);
        chk("fwrap_pp2", if_id_pc_plus2, 16'h0000);
        chk("fwrap_next", imem_addr, 16'h0000);
        tick(2);

        rst = 1'b1;
        stall = 1'b1;
        tick(1);
        rst = 1'b0;
        stall = 1'b0;
        chk("rst_stall_addr", imem_addr, 16'h0000);
        flush = 1'b1;
        branch_target = 16'h0060;
        tick(1);
        flush = 1'b0;
        tick(6);
        chk("h5_count", instr_count, 16'h0005);
        chk("h5_halted", {15'd0, halted}, 16'h0001);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("hrst_addr", imem_addr, 16'h0000);
        chk("hrst_halted", {15'd0, halted}, 16'h0000);
        chk("hrst_count", instr_count, 16'h0000);
        chk("hrst_valid", {15'd0, if_id_valid}, 16'h0000);
        tick(3);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
